icache_responder: RTL and testbench
===================================

Name: icache_responder

Overview:
- Instruction-memory responder that serves the fetch stage's requests.
- Accepts a 16-bit PC byte address and returns the full 128-bit (8-word) line containing it; the fetch side selects the word using address[3:1].
- Read-only, direct-mapped cache between the fetch stage and physical memory. It fills from physical memory on a miss.

Parameters:
- NUM_SETS, 8, number of lines; power of two, 2..64. INDEX_W = log2(NUM_SETS), TAG_W = 12 - INDEX_W.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- imem_read  in  1  fetch request valid
- imem_address  in  16  fetch byte address (lc3b_word); [3:0] offset, [3+INDEX_W:4] index, [15:4+INDEX_W] tag
- imem_rdata  out  128  line data (lc3b_data); word k sits at bits [16k+15:16k]
- imem_resp  out  1  imem_rdata valid for the current imem_address this cycle
- flush  in  1  single-cycle pulse; invalidates all lines
- pmem_read  out  1  line-fill request to physical memory
- pmem_address  out  16  fill address, always {tag,index,4'b0000}
- pmem_rdata  in  128  fill data
- pmem_resp  in  1  fill data valid this cycle
- miss_count  out  16  saturating count of misses since reset

Behaviour:
- Storage:
  - Per set: valid bit, TAG_W-bit tag, 128-bit data.
  - Data and tag arrays are not reset. Valid bits reset to 0.
- Reset values: state=IDLE, all valid=0, imem_resp=0, pmem_read=0, pmem_address=0, miss_count=0, imem_rdata=0.
- Hit:
  - hit = imem_read & valid[index] & (tag_array[index]==tag).
  - Zero-latency: in IDLE, imem_resp=hit and imem_rdata=data_array[index], both combinational in the same cycle.
  - When no hit, imem_rdata=0.
- FSM states: IDLE, FILL.
  - IDLE -> FILL: at the clock edge where imem_read & !hit & !flush.
    - Latch fill_addr = {imem_address[15:4],4'b0}.
    - Increment miss_count, saturating at 16'hFFFF.
  - In FILL:
    - pmem_read=1 and pmem_address=fill_addr, both held stable until pmem_resp.
    - imem_resp=0.
  - FILL -> IDLE: at the edge where pmem_resp=1.
    - Write pmem_rdata and the tag into the set indexed by fill_addr.
    - Set valid, unless discard is pending (see Flush).
  - The request re-presented in the cycle after the fill edge hits. Miss-to-resp latency is (pmem latency + 1) cycles after entry to FILL.
  - In IDLE, pmem_read=0 and pmem_address holds its last value.
- Request changes during FILL:
  - imem_address changes or imem_read drops: the fill completes for the latched fill_addr.
  - No abort. No second outstanding fill.
- Flush:
  - In any state, flush clears all valid bits at that edge. An IDLE miss in the same cycle as flush does not start a fill.
  - Flush during FILL: sets a discard flag. The in-flight line is written but its valid bit is left 0. The flag clears on return to IDLE.
  - flush coincident with pmem_resp: the line is discarded.
- Reset mid-FILL:
  - Immediate return to IDLE, pmem_read deasserts asynchronously, valids cleared.
  - Any later pmem_resp while in IDLE is ignored.
- pmem_resp while in IDLE: ignored, no array writes.
- Index/tag width follow NUM_SETS. Addresses differing only in [3:0] map to the same line.

Test Plan:
- Cold miss:
  - Stimulus: after reset, imem_read=1, addr=16'h3006; pmem returns 128'h0007_0006_..._0000 after 3 cycles.
  - Required: pmem_read high for exactly 3 cycles with pmem_address=16'h3000.
  - Required: one cycle later, imem_resp=1 and imem_rdata equals the fill data.
  - Required: miss_count=1.
- Hit:
  - Stimulus: after the above, addr=16'h300E.
  - Required: imem_resp=1 in the same cycle, pmem_read=0, miss_count stays 1.
- Conflict:
  - Stimulus: with NUM_SETS=8, fill 16'h3000, then request 16'h3080 (same index 0, different tag).
  - Required: miss and fill from 16'h3080.
  - Required: a subsequent request to 16'h3000 misses again; miss_count=3.
- Address change mid-fill:
  - Stimulus: miss on 16'h1000, then switch addr to 16'h2000 during FILL.
  - Required: pmem_address stays 16'h1000 until pmem_resp.
  - Required: 16'h1000 then hits, and 16'h2000 then misses.
- Flush:
  - Stimulus: flush pulse in IDLE with 16'h3000 cached.
  - Required: the next request to 16'h3000 misses.
  - Stimulus: flush pulse during FILL of 16'h4000.
  - Required: the fill completes, and 16'h4000 still misses afterwards.
- Reset mid-fill:
  - Stimulus: assert reset while pmem_read=1.
  - Required: pmem_read=0 immediately (no clock edge needed), miss_count=0.
  - Required: a late pmem_resp is ignored; the following request to the same address misses.

Source files
------------

// File: rtl/icache_responder_if.sv
// Fetch-side and physical-memory-side signal bundle
// for the direct-mapped instruction cache responder.
interface icache_responder_if;
    logic         imem_read;
    logic [15:0]  imem_address;
    logic [127:0] imem_rdata;
    logic         imem_resp;
    logic         flush;
    logic         pmem_read;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic [15:0]  miss_count;

    modport master (
        output imem_read, imem_address, flush,
        output pmem_rdata, pmem_resp,
        input  imem_rdata, imem_resp,
        input  pmem_read, pmem_address, miss_count
    );

    modport slave (
        input  imem_read, imem_address, flush,
        input  pmem_rdata, pmem_resp,
        output imem_rdata, imem_resp,
        output pmem_read, pmem_address, miss_count
    );
endinterface

// File: rtl/icache_responder.sv
// Read-only direct-mapped instruction cache: zero-latency hits,
// single outstanding line fill from physical memory on a miss.
module icache_responder #(
    parameter int NUM_SETS = 8
) (
    input  logic clk,
    input  logic reset,
    icache_responder_if.slave bus
);
    localparam int INDEX_W = $clog2(NUM_SETS);
    localparam int TAG_W   = 12 - INDEX_W;

    typedef enum logic {IDLE, FILL} state_e;

    state_e             state_q, state_d;
    logic               pread_q, pread_d;
    logic [15:0]        paddr_q, paddr_d;
    logic [15:0]        miss_q, miss_d;
    logic               discard_q, discard_d;
    logic [NUM_SETS-1:0] valid_q, valid_d;

    logic [127:0]     data_q [NUM_SETS];
    logic [TAG_W-1:0] tag_q  [NUM_SETS];

    logic [INDEX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0]   req_tag, fill_tag;
    logic               hit, fill_we;
    logic               unused_ok;

    assign req_idx  = bus.imem_address[3+INDEX_W:4];
    assign req_tag  = bus.imem_address[15:4+INDEX_W];
    // The held fill address doubles as the latched miss line address.
    assign fill_idx = paddr_q[3+INDEX_W:4];
    assign fill_tag = paddr_q[15:4+INDEX_W];
    assign unused_ok = ^bus.imem_address[3:0];

    assign hit = bus.imem_read & valid_q[req_idx]
               & (tag_q[req_idx] == req_tag);

    assign bus.imem_resp    = (state_q == IDLE) & hit;
    assign bus.imem_rdata   = bus.imem_resp ? data_q[req_idx] : '0;
    assign bus.pmem_read    = pread_q;
    assign bus.pmem_address = paddr_q;
    assign bus.miss_count   = miss_q;

    always_comb begin
        state_d   = state_q;
        pread_d   = pread_q;
        paddr_d   = paddr_q;
        miss_d    = miss_q;
        discard_d = discard_q;
        valid_d   = valid_q;
        fill_we   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.imem_read & !hit & !bus.flush) begin
                    state_d   = FILL;
                    pread_d   = 1'b1;
                    paddr_d   = {bus.imem_address[15:4], 4'b0000};
                    discard_d = 1'b0;
                    if (miss_q != 16'hFFFF)
                        miss_d = miss_q + 16'd1;
                end
            end
            FILL: begin
                if (bus.pmem_resp) begin
                    state_d   = IDLE;
                    pread_d   = 1'b0;
                    fill_we   = 1'b1;
                    discard_d = 1'b0;
                end else if (bus.flush) begin
                    discard_d = 1'b1;
                end
            end
        endcase
        if (bus.flush)
            valid_d = '0;
        // A flush at or before the fill edge leaves the new line invalid.
        if (fill_we & !discard_q & !bus.flush)
            valid_d[fill_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pread_q   <= 1'b0;
            paddr_q   <= '0;
            miss_q    <= '0;
            discard_q <= 1'b0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            pread_q   <= pread_d;
            paddr_q   <= paddr_d;
            miss_q    <= miss_d;
            discard_q <= discard_d;
            valid_q   <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_q[fill_idx] <= bus.pmem_rdata;
            tag_q[fill_idx]  <= fill_tag;
        end
    end
endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: table-driven vectors
// plus hand sequences for mid-fill, flush and reset corners.
module tb_icache_responder;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    icache_responder_if bus();

    icache_responder #(.NUM_SETS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rd;
        logic [15:0]  addr;
        logic         fl;
        logic         presp;
        logic [127:0] pdata;
        logic         e_resp;
        logic [127:0] e_rdata;
        logic         e_pread;
        logic [15:0]  e_paddr;
        logic [15:0]  e_miss;
    } vec_t;

    vec_t vecs[$];

    localparam logic [127:0] D0 =
        128'h0007_0006_0005_0004_0003_0002_0001_0000;

    function automatic logic [127:0] line(input logic [15:0] a);
        logic [127:0] l;
        for (int k = 0; k < 8; k++)
            l[16*k +: 16] = a + 16'(k);
        return l;
    endfunction

    function automatic vec_t mk(
        input logic rd, input logic [15:0] addr,
        input logic fl, input logic presp,
        input logic [127:0] pdata,
        input logic e_resp, input logic [127:0] e_rdata,
        input logic e_pread, input logic [15:0] e_paddr,
        input logic [15:0] e_miss);
        vec_t v;
        v.rd = rd; v.addr = addr; v.fl = fl;
        v.presp = presp; v.pdata = pdata;
        v.e_resp = e_resp; v.e_rdata = e_rdata;
        v.e_pread = e_pread; v.e_paddr = e_paddr;
        v.e_miss = e_miss;
        return v;
    endfunction

    task automatic chk(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic [15:0] a,
                       input logic f, input logic pr,
                       input logic [127:0] pd);
        @(negedge clk);
        bus.imem_read    = r;
        bus.imem_address = a;
        bus.flush        = f;
        bus.pmem_resp    = pr;
        bus.pmem_rdata   = pd;
        #1;
    endtask

    task automatic obs(input string nm, input logic e_resp,
                       input logic [127:0] e_rdata,
                       input logic e_pread,
                       input logic [15:0] e_paddr,
                       input logic [15:0] e_miss);
        chk({nm, ".resp"}, 128'(bus.imem_resp), 128'(e_resp));
        chk({nm, ".rdata"}, bus.imem_rdata, e_rdata);
        chk({nm, ".pread"}, 128'(bus.pmem_read), 128'(e_pread));
        chk({nm, ".paddr"}, 128'(bus.pmem_address), 128'(e_paddr));
        chk({nm, ".miss"}, 128'(bus.miss_count), 128'(e_miss));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.imem_read    = 1'b0;
        bus.imem_address = '0;
        bus.flush        = 1'b0;
        bus.pmem_resp    = 1'b0;
        bus.pmem_rdata   = '0;

        // cold miss, hit, conflict, read low, stray pmem_resp
        vecs.push_back(mk(1, 16'h3006, 0, 0, 0,   0, 0,  0, 16'h0000, 1));
        vecs[0].e_miss = 0;
        vecs.push_back(mk(1, 16'h3006, 0, 0, 0,   0, 0,  1, 16'h3000, 1));
        vecs.push_back(mk(1, 16'h3006, 0, 0, 0,   0, 0,  1, 16'h3000, 1));
        vecs.push_back(mk(1, 16'h3006, 0, 1, D0,  0, 0,  1, 16'h3000, 1));
        vecs.push_back(mk(1, 16'h3006, 0, 0, 0,   1, D0, 0, 16'h3000, 1));
        vecs.push_back(mk(1, 16'h300E, 0, 0, 0,   1, D0, 0, 16'h3000, 1));
        vecs.push_back(mk(1, 16'h3080, 0, 0, 0,   0, 0,  0, 16'h3000, 1));
        vecs.push_back(mk(1, 16'h3080, 0, 1, line(16'h3080),
                          0, 0, 1, 16'h3080, 2));
        vecs.push_back(mk(1, 16'h3080, 0, 0, 0,
                          1, line(16'h3080), 0, 16'h3080, 2));
        vecs.push_back(mk(1, 16'h3000, 0, 0, 0,   0, 0,  0, 16'h3080, 2));
        vecs.push_back(mk(1, 16'h3000, 0, 1, line(16'h3000),
                          0, 0, 1, 16'h3000, 3));
        vecs.push_back(mk(1, 16'h3004, 0, 0, 0,
                          1, line(16'h3000), 0, 16'h3000, 3));
        vecs.push_back(mk(0, 16'h3000, 0, 0, 0,   0, 0,  0, 16'h3000, 3));
        vecs.push_back(mk(0, 16'h3000, 0, 1, {8{16'hDEAD}},
                          0, 0, 0, 16'h3000, 3));
        vecs.push_back(mk(1, 16'h3000, 0, 0, 0,
                          1, line(16'h3000), 0, 16'h3000, 3));

        cyc(0, 16'h0000, 0, 0, 0);
        obs("reset", 0, 0, 0, 16'h0000, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rd, vecs[i].addr, vecs[i].fl,
                vecs[i].presp, vecs[i].pdata);
            obs($sformatf("vec%0d", i), vecs[i].e_resp,
                vecs[i].e_rdata, vecs[i].e_pread,
                vecs[i].e_paddr, vecs[i].e_miss);
        end

        // address change mid-fill
        cyc(1, 16'h1000, 0, 0, 0);
        obs("mid.miss", 0, 0, 0, 16'h3000, 3);
        cyc(1, 16'h2000, 0, 0, 0);
        obs("mid.f1", 0, 0, 1, 16'h1000, 4);
        cyc(1, 16'h2000, 0, 0, 0);
        obs("mid.f2", 0, 0, 1, 16'h1000, 4);
        cyc(1, 16'h2000, 0, 1, line(16'h1000));
        obs("mid.f3", 0, 0, 1, 16'h1000, 4);
        cyc(1, 16'h1000, 0, 0, 0);
        obs("mid.hit", 1, line(16'h1000), 0, 16'h1000, 4);
        cyc(1, 16'h2000, 0, 0, 0);
        obs("mid.other", 0, 0, 0, 16'h1000, 4);
        cyc(1, 16'h2000, 0, 1, line(16'h2000));
        obs("mid.fill2", 0, 0, 1, 16'h2000, 5);

        // flush in IDLE, flush coincident with a miss
        cyc(1, 16'h3000, 0, 0, 0);
        obs("fl.miss", 0, 0, 0, 16'h2000, 5);
        cyc(1, 16'h3000, 0, 1, line(16'h3000));
        obs("fl.fill", 0, 0, 1, 16'h3000, 6);
        cyc(1, 16'h3000, 0, 0, 0);
        obs("fl.hit", 1, line(16'h3000), 0, 16'h3000, 6);
        cyc(0, 16'h3000, 1, 0, 0);
        obs("fl.pulse", 0, 0, 0, 16'h3000, 6);
        cyc(1, 16'h3000, 1, 0, 0);
        obs("fl.missflush", 0, 0, 0, 16'h3000, 6);
        cyc(1, 16'h3000, 0, 0, 0);
        obs("fl.nofill", 0, 0, 0, 16'h3000, 6);
        cyc(1, 16'h3000, 0, 1, line(16'h3000));
        obs("fl.refill", 0, 0, 1, 16'h3000, 7);

        // flush during FILL discards the line
        cyc(1, 16'h4000, 0, 0, 0);
        obs("fd.miss", 0, 0, 0, 16'h3000, 7);
        cyc(1, 16'h4000, 1, 0, 0);
        obs("fd.flush", 0, 0, 1, 16'h4000, 8);
        cyc(1, 16'h4000, 0, 1, line(16'h4000));
        obs("fd.resp", 0, 0, 1, 16'h4000, 8);
        cyc(1, 16'h4000, 0, 0, 0);
        obs("fd.stillmiss", 0, 0, 0, 16'h4000, 8);
        cyc(1, 16'h4000, 0, 1, line(16'h4000));
        obs("fd.refill", 0, 0, 1, 16'h4000, 9);
        cyc(1, 16'h4000, 0, 0, 0);
        obs("fd.hit", 1, line(16'h4000), 0, 16'h4000, 9);

        // flush coincident with pmem_resp
        cyc(1, 16'h5000, 0, 0, 0);
        obs("fc.miss", 0, 0, 0, 16'h4000, 9);
        cyc(1, 16'h5000, 1, 1, line(16'h5000));
        obs("fc.resp", 0, 0, 1, 16'h5000, 10);
        cyc(1, 16'h5000, 0, 0, 0);
        obs("fc.stillmiss", 0, 0, 0, 16'h5000, 10);
        cyc(1, 16'h5000, 0, 0, 0);
        obs("fc.fill", 0, 0, 1, 16'h5000, 11);

        // asynchronous reset while filling
        #2;
        reset = 1'b1;
        #1;
        obs("rst.async", 0, 0, 0, 16'h0000, 0);
        cyc(0, 16'h5000, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        cyc(0, 16'h5000, 0, 1, line(16'h5000));
        obs("rst.late", 0, 0, 0, 16'h0000, 0);
        cyc(1, 16'h5000, 0, 0, 0);
        obs("rst.miss", 0, 0, 0, 16'h0000, 0);
        cyc(1, 16'h5000, 0, 0, 0);
        obs("rst.fill", 0, 0, 1, 16'h5000, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
